// File: rtl/extrema_scan_ctrl.sv
// Frame controller that folds a stream of unsigned samples into running
// maximum and minimum registers, time-sharing one external max/min
// comparator (two comparator passes per sample).
module extrema_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    output logic             cmp_m,
    input  logic [WIDTH-1:0] cmp_y,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    // Stream handshake: in_ready is a pure function of state (high only in
    // ACCEPT). A sample transfers on a rising edge where in_valid && in_ready;
    // in_data is don't-care on every other edge. The source may hold in_valid
    // for any number of cycles; there is no timeout.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        CMP_MAX = 3'd2,
        CMP_MIN = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] sample_q;
    logic [CNT_W-1:0] remaining_q;

    // State register plus datapath registers; the comparator result is
    // captured into max or min depending on which pass is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            max_q       <= '0;
            min_q       <= '0;
            sample_q    <= '0;
            remaining_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Identities for unsigned max/min so the first sample wins both.
                        remaining_q <= len;
                        max_q       <= '0;
                        min_q       <= '1;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        sample_q    <= in_data;
                        remaining_q <= remaining_q - CNT_W'(1);
                    end
                end
                CMP_MAX: max_q <= cmp_y;
                CMP_MIN: min_q <= cmp_y;
                default: ;
            endcase
        end
    end

    // Next-state and Moore outputs; comparator operands are zero outside
    // the compare passes so the shared comparator never sees X.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        cmp_a     = '0;
        cmp_b     = '0;
        cmp_m     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CMP_MAX;
                end
            end
            CMP_MAX: begin
                cmp_a     = max_q;
                cmp_b     = sample_q;
                cmp_m     = 1'b0;
                state_nxt = CMP_MIN;
            end
            CMP_MIN: begin
                cmp_a     = min_q;
                cmp_b     = sample_q;
                cmp_m     = 1'b1;
                state_nxt = (remaining_q == '0) ? DONE : ACCEPT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign max_out   = max_q;
    assign min_out   = min_q;
    assign state_dbg = state;

endmodule
